// File: rtl/dma_dsc_out_arb_pkg.sv
// Shared DMA descriptor types, credit return format, scheduler states and the credit ceiling.
package dma_dsc_out_arb_pkg;

    localparam int unsigned DMA_MAX_CRD   = 64;
    localparam int unsigned DMA_CRD_RET_W = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
        logic [7:0]  tag;
    } dma_dsc_block_t;

    typedef struct packed {
        logic                     vld;
        logic [DMA_CRD_RET_W-1:0] cnt;
    } dma_dsc_out_crd_t;

    typedef enum logic [1:0] {
        StStop,
        StRun,
        StDrain
    } dma_arb_st_e;

endpackage

// File: rtl/dma_pcie_dsc_out_if.sv
// Descriptor output channel: source drives a one-cycle valid beat, sink returns credits.
interface dma_pcie_dsc_out_if;
    import dma_dsc_out_arb_pkg::*;

    logic             dsc_vld;
    dma_dsc_block_t   dsc;
    dma_dsc_out_crd_t crd;

    modport src (output dsc_vld, output dsc, input crd);
    modport snk (input dsc_vld, input dsc, output crd);

endinterface

// File: rtl/dma_rr_arb.sv
// Round-robin arbiter: priority starts one above the last granted index; pointer moves only on grant.
module dma_rr_arb #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               gnt_en,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        gnt       = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = r_ptr;
        w_found   = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_idx = PTR_W'((32'(r_ptr) + off) % NUM_REQ);
            if (!w_found && gnt_en && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_ptr_nxt  = w_idx;
                w_found    = 1'b1;
            end
        end
    end

    // Reset to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/dma_dsc_out_arb.sv
// Credit-gated round-robin descriptor scheduler with STOP/RUN/DRAIN control.
// Optional per-requester grant counters enabled by DMA_DSC_OUT_ARB_STATS_EN.
module dma_dsc_out_arb
    import dma_dsc_out_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CRD_W   = 8,
    parameter int unsigned MAX_CRD = DMA_MAX_CRD
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic           [NUM_REQ-1:0] req_vld,
    input  dma_dsc_block_t [NUM_REQ-1:0] req_dsc,
    output logic           [NUM_REQ-1:0] req_rdy,
    dma_pcie_dsc_out_if.src              dsc_out,
    output logic           [CRD_W-1:0]   crd_avail,
    output logic                         crd_ovf,
    output logic                         idle
`ifdef DMA_DSC_OUT_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]     grant_cnt
`endif
);

    localparam int unsigned SUM_W = CRD_W + DMA_CRD_RET_W;

    dma_arb_st_e        r_state;
    dma_arb_st_e        w_state_nxt;
    logic [CRD_W-1:0]   r_crd;
    logic [CRD_W-1:0]   w_crd_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               r_out_vld;
    dma_dsc_block_t     r_out_dsc;
    dma_dsc_block_t     w_sel_dsc;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_en;
    logic               w_fire;
    logic [SUM_W-1:0]   w_ret;
    logic [SUM_W-1:0]   w_sum;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StStop:  if (en) w_state_nxt = StRun;
            StRun:   if (!en) w_state_nxt = StDrain;
            StDrain: begin
                if (en) begin
                    w_state_nxt = StRun;
                end else if (!r_out_vld) begin
                    w_state_nxt = StStop;
                end
            end
            default: w_state_nxt = StStop;
        endcase
    end

    // Grants are decided on state, not en, so a grant in the cycle en falls still completes.
    assign w_gnt_en = (r_state == StRun) && (r_crd != '0);

    dma_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vld),
        .gnt_en (w_gnt_en),
        .gnt    (w_gnt)
    );

    assign req_rdy = w_gnt;
    assign w_fire  = |w_gnt;

    always_comb begin
        w_sel_dsc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_sel_dsc = req_dsc[i];
        end
    end

    // Wide enough that return plus current count cannot wrap before the saturation test.
    assign w_ret = dsc_out.crd.vld ? SUM_W'(dsc_out.crd.cnt) : '0;
    assign w_sum = SUM_W'(r_crd) + w_ret - SUM_W'(w_fire);

    always_comb begin
        w_crd_nxt = w_sum[CRD_W-1:0];
        w_ovf_nxt = r_ovf;
        if (w_sum > SUM_W'(MAX_CRD)) begin
            w_crd_nxt = CRD_W'(MAX_CRD);
            w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StStop;
            r_crd     <= '0;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_dsc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_crd     <= w_crd_nxt;
            r_ovf     <= w_ovf_nxt;
            r_out_vld <= w_fire;
            if (w_fire) r_out_dsc <= w_sel_dsc;
        end
    end

    assign dsc_out.dsc_vld = r_out_vld;
    assign dsc_out.dsc     = r_out_dsc;
    assign crd_avail       = r_crd;
    assign crd_ovf         = r_ovf;
    assign idle            = (r_state == StStop) && !r_out_vld;

`ifdef DMA_DSC_OUT_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] r_grant_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_dma_dsc_out_arb.sv
// Scoreboard bench for dma_dsc_out_arb: directed scenarios push expected beats, a monitor pops them.
module tb_dma_dsc_out_arb;
    import dma_dsc_out_arb_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned MAXC = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic           [NREQ-1:0] req_vld;
    dma_dsc_block_t [NREQ-1:0] req_dsc;
    logic           [NREQ-1:0] req_rdy;
    logic           [CW-1:0]   crd_avail;
    logic                      crd_ovf;
    logic                      idle;
`ifdef DMA_DSC_OUT_ARB_STATS_EN
    logic [NREQ-1:0][31:0]     grant_cnt;
`endif

    dma_pcie_dsc_out_if u_if ();

    always #5 clk = ~clk;

    dma_dsc_out_arb #(
        .NUM_REQ (NREQ),
        .CRD_W   (CW),
        .MAX_CRD (MAXC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_vld   (req_vld),
        .req_dsc   (req_dsc),
        .req_rdy   (req_rdy),
        .dsc_out   (u_if),
        .crd_avail (crd_avail),
        .crd_ovf   (crd_ovf),
        .idle      (idle)
`ifdef DMA_DSC_OUT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int             checks = 0;
    int             errors = 0;
    dma_dsc_block_t sb_q[$];
    int unsigned    rem[NREQ];
    int unsigned    seq[NREQ];
    logic           prev_fire = 1'b0;

    function automatic dma_dsc_block_t mk_dsc(int unsigned i, int unsigned s);
        dma_dsc_block_t d;
        d.addr = 32'h1000_0000 + (i << 16) + s;
        d.len  = 16'(64 + s);
        d.tag  = 8'(i * 16 + s);
        return d;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i] = (rem[i] != 0);
            req_dsc[i] = mk_dsc(i, seq[i]);
        end
    endtask

    // One cycle: sample handshakes before the edge, advance requester queues after it.
    task automatic step();
        logic [NREQ-1:0] f;
        @(negedge clk);
        f = req_vld & req_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (f[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        drive_req();
    endtask

    task automatic ret_crd(int unsigned n);
        u_if.crd.vld = 1'b1;
        u_if.crd.cnt = 8'(n);
        step();
        u_if.crd = '0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        u_if.crd = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        drive_req();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every beat must follow a handshake by one cycle and match the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fire = 1'b0;
        end else begin
            if (u_if.dsc_vld || prev_fire) chk("beat_timing", u_if.dsc_vld, prev_fire);
            if (u_if.dsc_vld) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h, scoreboard empty", u_if.dsc);
                end else begin
                    chk("beat_dsc", u_if.dsc, sb_q.pop_front());
                end
            end
            if (req_vld != '0) chk("rdy_onehot0", $onehot0(req_rdy), 1);
            prev_fire = |(req_vld & req_rdy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        u_if.crd = '0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive_req();
        @(negedge clk);
        chk("rst_crd", crd_avail, 0);
        chk("rst_ovf", crd_ovf, 0);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_vld", u_if.dsc_vld, 0);
        chk("rst_idle", idle, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 4 credits, requester 0 holds 6 descriptors: exactly 4 beats.
        en     = 1'b1;
        rem[0] = 6;
        drive_req();
        for (int k = 0; k < 4; k++) sb_q.push_back(mk_dsc(0, seq[0] + k));
        ret_crd(4);
        repeat (7) step();
        chk("t1_crd", crd_avail, 0);
        chk("t1_rdy", req_rdy, 0);
        chk("t1_beats", rem[0], 2);
        chk("t1_sb_empty", sb_q.size(), 0);

        // Fresh pointer, both requesting: 0,1,0,1...
        do_reset();
        en     = 1'b1;
        rem[0] = 5;
        rem[1] = 5;
        drive_req();
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(mk_dsc(0, seq[0] + k));
            sb_q.push_back(mk_dsc(1, seq[1] + k));
        end
        ret_crd(8);
        repeat (11) step();
        chk("t2_crd", crd_avail, 0);
        chk("t2_rem0", rem[0], 1);
        chk("t2_rem1", rem[1], 1);
        chk("t2_sb_empty", sb_q.size(), 0);

        // Grant and return of 3 in the same cycle at one credit.
        rem[0] = 0;
        rem[1] = 0;
        drive_req();
        ret_crd(1);
        chk("t3_crd1", crd_avail, 1);
        rem[1] = 1;
        drive_req();
        sb_q.push_back(mk_dsc(1, seq[1]));
        ret_crd(3);
        chk("t3_crd3", crd_avail, 3);
        repeat (2) step();
        chk("t3_sb_empty", sb_q.size(), 0);

        // Saturation at MAX_CRD with sticky overflow.
        ret_crd(MAXC - 2 - 3);
        chk("t4_crd_pre", crd_avail, MAXC - 2);
        chk("t4_ovf_pre", crd_ovf, 0);
        ret_crd(5);
        chk("t4_crd_sat", crd_avail, MAXC);
        chk("t4_ovf_set", crd_ovf, 1);
        rem[0] = 2;
        drive_req();
        sb_q.push_back(mk_dsc(0, seq[0]));
        sb_q.push_back(mk_dsc(0, seq[0] + 1));
        repeat (4) step();
        chk("t4_crd_after", crd_avail, MAXC - 2);
        chk("t4_ovf_held", crd_ovf, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_ovf_clr", crd_ovf, 0);
        chk("t4_crd_clr", crd_avail, 0);
        do_reset();

        // en falls in the grant cycle: beat still emitted, then STOP; credits still counted.
        en = 1'b1;
        ret_crd(2);
        rem[0] = 2;
        en     = 1'b0;
        drive_req();
        sb_q.push_back(mk_dsc(0, seq[0]));
        step();
        chk("t5_idle_drain", idle, 0);
        chk("t5_rdy_drain", req_rdy, 0);
        ret_crd(3);
        step();
        chk("t5_idle_stop", idle, 1);
        chk("t5_rdy_stop", req_rdy, 0);
        chk("t5_crd", crd_avail, 4);
        ret_crd(1);
        chk("t5_crd_stop_ret", crd_avail, 5);
        chk("t5_one_beat", rem[0], 1);
        chk("t5_sb_empty", sb_q.size(), 0);

        // Reset while the output beat is valid.
        en = 1'b1;
        step();
        step();
        chk("t6_vld_hi", u_if.dsc_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_vld_lo", u_if.dsc_vld, 0);
        chk("t6_crd", crd_avail, 0);
        chk("t6_idle", idle, 1);
        chk("t6_rdy", req_rdy, 0);
        chk("final_sb_empty", sb_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_dsc_out_arb.md
DMA_DSC_OUT_ARB -- requirements
Module: dma_dsc_out_arb

Interface
REQ-001 The block SHALL provide parameter NUM_REQ, default 2, number of descriptor requesters (2..8).
REQ-002 The block SHALL provide parameter CRD_W, default 8, width of the internal credit counter.
REQ-003 The block SHALL provide parameter MAX_CRD, default 64, credit ceiling (must be < 2**CRD_W).
REQ-004 The block SHALL provide port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL provide port en  input  1  scheduler enable; low requests a graceful stop.
REQ-007 The block SHALL provide port req_vld  input  NUM_REQ  per-requester descriptor valid.
REQ-008 The block SHALL provide port req_dsc  input  NUM_REQ x dma_dsc_block_t  per-requester descriptor payload.
REQ-009 The block SHALL provide port req_rdy  output  NUM_REQ  one-hot acceptance; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
REQ-010 The block SHALL provide port dsc_out  interface  dma_pcie_dsc_out_if.src  dsc driven to the sink; crd returned by the sink as a valid plus a count.
REQ-011 The block SHALL provide port crd_avail  output  CRD_W  current credit count.
REQ-012 The block SHALL provide port crd_ovf  output  1  sticky credit-overflow error.
REQ-013 The block SHALL provide port idle  output  1  high in state STOP with no descriptor in flight.

Function
REQ-014 The block SHALL implement states STOP, RUN and DRAIN.
REQ-015 STOP SHALL move to RUN when en=1; RUN SHALL move to DRAIN when en=0; DRAIN SHALL move to STOP once the output register is empty, or to RUN if en returns to 1 first.
REQ-016 In RUN, a grant SHALL issue only when crd_avail>0 and at least one req_vld is set; in STOP and DRAIN, req_rdy SHALL be all zero.
REQ-017 Arbitration SHALL be round-robin: priority starts one index above the last granted requester; after reset the last-granted index SHALL be NUM_REQ-1, so index 0 has first priority.
REQ-018 At most one descriptor SHALL be granted per cycle, and req_rdy SHALL be one-hot or zero.
REQ-019 A granted descriptor SHALL appear on dsc_out.dsc with its valid set exactly one cycle after the grant cycle, and valid SHALL stay high for exactly one cycle (no back-pressure; credits guarantee acceptance).
REQ-020 On each grant, the credit count SHALL decrement by 1; on a credit return, it SHALL increment by the returned count.
REQ-021 When a grant and a credit return occur in the same cycle, the net result SHALL be count + returned - 1.
REQ-022 If an increment would exceed MAX_CRD, the count SHALL saturate at MAX_CRD and crd_ovf SHALL set and remain set until reset.
REQ-023 At zero credits, req_rdy SHALL be zero in that same cycle; a credit returned in cycle N SHALL enable a grant no earlier than cycle N+1.
REQ-024 Credits returned in any state SHALL be counted, including STOP.
REQ-025 The round-robin pointer SHALL update only on a grant.

Reset
REQ-026 While rst_n=0, the block SHALL hold state STOP, crd_avail=0, crd_ovf=0, req_rdy=0, dsc_out.dsc valid=0, idle=1 and pointer=NUM_REQ-1.
REQ-027 Reset asserted mid-transfer SHALL drop the output valid immediately (asynchronously) and discard all credits; the sink re-advertises its credits after reset.

Configuration
REQ-028 With DMA_DSC_OUT_ARB_STATS_EN defined, the block SHALL provide an output port grant_cnt (NUM_REQ x 32).
REQ-029 Each grant_cnt entry SHALL increment once per grant to its requester, wrap at 2**32, and reset to 0.
REQ-030 Without DMA_DSC_OUT_ARB_STATS_EN, neither grant_cnt nor its counters SHALL exist.

Structure
REQ-031 The state enumeration and the MAX_CRD default SHALL reside in the shared dma package alongside dma_dsc_block_t and dma_dsc_out_crd_t.
REQ-032 The round-robin arbiter SHALL be a separate sub-module, dma_rr_arb (request vector, grant enable, one-hot grant out, registered pointer).

Verification
REQ-033 The bench SHALL cover: reset, en=1, sink returns 4 credits, requester 0 holds 6 descriptors -> exactly 4 output beats, each 1 cycle after its grant, then crd_avail=0 and req_rdy=0.
REQ-034 The bench SHALL cover: 8 credits, req_vld=2'b11 held continuously -> grants alternate 0,1,0,1..., with index 0 first.
REQ-035 The bench SHALL cover: crd_avail=1, a grant and a return of 3 in the same cycle -> crd_avail=3 next cycle.
REQ-036 The bench SHALL cover: crd_avail=MAX_CRD-2, return of 5 -> crd_avail=MAX_CRD and crd_ovf=1, held through later traffic until rst_n low.
REQ-037 The bench SHALL cover: en dropped in the cycle of a grant -> that descriptor is still emitted, then STOP, idle=1 and req_rdy=0, while credit returns are still counted.
REQ-038 The bench SHALL cover: rst_n asserted while output valid is high -> valid low with no clock edge, and crd_avail=0.
